regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two write-back requesters: the ALU path (req 0) and the memory/load path (req 1).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write one cycle, then drives address, data, write enable and the 32-bit one-hot row enable into the register file.
- Writes to the zero register are accepted but suppressed.
- Keeps a saturating conflict counter for performance debug.

Parameters:
DATA_W, 64, width of write-back data
ZERO_REG, 31, register index whose writes are suppressed (XZR)
CNT_W, 8, width of saturating conflict counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
hold_i  input  1  register file unavailable; no grants while high
alu_valid_i  input  1  ALU write-back request
alu_addr_i  input  5  ALU destination register
alu_data_i  input  DATA_W  ALU result
alu_ready_o  output  1  ALU request accepted this cycle
mem_valid_i  input  1  load write-back request
mem_addr_i  input  5  load destination register
mem_data_i  input  DATA_W  load data
mem_ready_o  output  1  load request accepted this cycle
wr_en_o  output  1  register-file write enable (registered)
wr_addr_o  output  5  register-file write address (registered)
wr_data_o  output  DATA_W  register-file write data (registered)
wr_row_o  output  32  one-hot row enable; all-zero when wr_en_o=0
conflict_cnt_o  output  CNT_W  saturating count of cycles with both requests valid and hold_i low

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_row_o=0, conflict_cnt_o=0.
  - last_grant=MEM, so the ALU wins the first conflict.
  - Reset overrides all same-cycle requests; nothing accepted that cycle (ready outputs forced 0 while reset=1).
- Grant (combinational, per cycle):
  - hold_i=1: alu_ready_o=mem_ready_o=0.
  - Else, only one valid: that requester is ready.
  - Else, both valid: the requester not equal to last_grant is ready; the other is held.
  - Neither valid: both ready low.
  - A ready output is never high without its valid.
- Handshake:
  - A transfer occurs on valid&ready.
  - A requester must hold valid, addr and data stable until ready.
  - The arbiter never drops an unaccepted request.
- last_grant updates only on a transfer, to the granted requester.
- Output stage: on a transfer, the next edge loads wr_addr_o/wr_data_o from the winner. Latency is exactly 1 cycle, so throughput is one write per cycle.
  - wr_en_o=1 unless the addr equals ZERO_REG, in which case wr_en_o=0 and wr_row_o=0. The handshake still completes.
  - No transfer: wr_en_o=0 and wr_row_o=0 next cycle; wr_addr_o/wr_data_o hold their last value.
- wr_row_o = one-hot decode of wr_addr_o gated by wr_en_o, so exactly one bit is set when wr_en_o=1.
- Conflict counter:
  - Increments on each cycle with alu_valid_i & mem_valid_i & ~hold_i & ~reset.
  - Saturates at 2^CNT_W-1; no wrap.
- Same destination from both requesters in consecutive grants: both writes are issued in grant order, and the later write persists.
- hold_i asserted mid-stream: the write already registered still issues the next cycle; new grants stop immediately.
- Reset mid-stream: a pending registered write is discarded (wr_en_o=0 after the reset edge).

Decomposition:
- Shared package `wb_pkg`:
  - DATA_W and ZERO_REG constants.
  - An enum for requester id (REQ_ALU=0, REQ_MEM=1) used by last_grant.
- One sub-module: the existing 5:32 enabled decoder `Decoder_5x32`, instantiated with in_i=wr_addr_o, en_i=wr_en_o, out_o=wr_row_o.
- The arbiter, output register and counter live in the top module.

Test Plan:
- Reset then idle: assert reset 2 cycles, release, no valids -> wr_en_o=0, wr_row_o=0, conflict_cnt_o=0, both ready low.
- Single ALU write: alu_valid_i=1, addr=5, data=0xDEAD -> alu_ready_o=1 same cycle. Next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0xDEAD, wr_row_o=0x00000020.
- Continuous conflict: both valid for 4 cycles, ALU addr 1/2, MEM addr 3/4, each requester advancing only on its ready -> grants ALU, MEM, ALU, MEM; outputs addr 1,3,2,4 one cycle later; conflict_cnt_o=4 after 4 both-valid cycles.
- Zero-register write: mem_valid_i=1, addr=31 -> mem_ready_o=1; next cycle wr_en_o=0, wr_row_o=0.
- Hold: both valid, hold_i=1 for 3 cycles -> both ready 0, wr_en_o=0, conflict_cnt_o unchanged. Release -> ALU granted first after reset state.
- Saturation and mid-stream reset: CNT_W=8, 300 conflict cycles -> conflict_cnt_o=255. Then assert reset in the cycle after a grant -> wr_en_o=0 and conflict_cnt_o=0 after the reset edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared constants and requester id type for the write-back arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int C_DATA_W   = 64;
  localparam int C_ZERO_REG = 31;

  typedef enum logic [0:0] {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_decoder.sv
// ============================================================================
// Module  : Decoder_5x32
// Brief   : 5-to-32 one-hot decoder with enable; all-zero output when disabled.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module Decoder_5x32 (
  input  logic [4:0]  in_i,
  input  logic        en_i,
  output logic [31:0] out_o
);

  always_comb begin
    out_o = 32'd0;
    if (en_i) begin
      out_o = 32'd1 << in_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin share of the register-file write port between the ALU
//           and load write-back paths, with a registered output stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int ZERO_REG = C_ZERO_REG,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  input  logic              alu_valid_i,
  input  logic [4:0]        alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              mem_valid_i,
  input  logic [4:0]        mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  output logic              wr_en_o,
  output logic [4:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [31:0]       wr_row_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam logic [4:0]       C_ZERO_ADDR = 5'(ZERO_REG);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  req_id_e             r_last_grant;
  logic                r_wr_en;
  logic [4:0]          r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [CNT_W-1:0]    r_conflict_cnt;

  logic                w_alu_ready;
  logic                w_mem_ready;
  logic                w_alu_xfer;
  logic                w_mem_xfer;
  logic                w_conflict;

  assign w_conflict = alu_valid_i & mem_valid_i & ~hold_i & ~reset;

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    w_alu_ready = 1'b0;
    w_mem_ready = 1'b0;
    if (!reset && !hold_i) begin
      if (alu_valid_i && mem_valid_i) begin
        if (r_last_grant == REQ_MEM) begin
          w_alu_ready = 1'b1;
        end else begin
          w_mem_ready = 1'b1;
        end
      end else begin
        w_alu_ready = alu_valid_i;
        w_mem_ready = mem_valid_i;
      end
    end
  end

  assign w_alu_xfer = alu_valid_i & w_alu_ready;
  assign w_mem_xfer = mem_valid_i & w_mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ_MEM;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 5'd0;
      r_wr_data    <= '0;
    end else if (w_alu_xfer) begin
      r_last_grant <= REQ_ALU;
      r_wr_en      <= (alu_addr_i != C_ZERO_ADDR);
      r_wr_addr    <= alu_addr_i;
      r_wr_data    <= alu_data_i;
    end else if (w_mem_xfer) begin
      r_last_grant <= REQ_MEM;
      r_wr_en      <= (mem_addr_i != C_ZERO_ADDR);
      r_wr_addr    <= mem_addr_i;
      r_wr_data    <= mem_data_i;
    end else begin
      r_wr_en      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != C_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  Decoder_5x32 u_row_dec (
    .in_i  (r_wr_addr),
    .en_i  (r_wr_en),
    .out_o (wr_row_o)
  );

  assign alu_ready_o    = w_alu_ready;
  assign mem_ready_o    = w_mem_ready;
  assign wr_en_o        = r_wr_en;
  assign wr_addr_o      = r_wr_addr;
  assign wr_data_o      = r_wr_data;
  assign conflict_cnt_o = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed self-checking bench for regfile_wb_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold_i;
  logic              alu_valid_i;
  logic [4:0]        alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_ready_o;
  logic              mem_valid_i;
  logic [4:0]        mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ready_o;
  logic              wr_en_o;
  logic [4:0]        wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [31:0]       wr_row_o;
  logic [CNT_W-1:0]  conflict_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  int alu_q     [3] = '{1, 2, 6};
  int mem_q     [2] = '{3, 4};
  int exp_alu   [5] = '{1, 0, 1, 0, 1};
  int exp_addr  [5] = '{1, 3, 2, 4, 6};
  int exp_data  [5] = '{'hA001, 'hB003, 'hA002, 'hB004, 'hA006};

  regfile_wb_arbiter #(
    .DATA_W   (DATA_W),
    .ZERO_REG (31),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hold_i         (hold_i),
    .alu_valid_i    (alu_valid_i),
    .alu_addr_i     (alu_addr_i),
    .alu_data_i     (alu_data_i),
    .alu_ready_o    (alu_ready_o),
    .mem_valid_i    (mem_valid_i),
    .mem_addr_i     (mem_addr_i),
    .mem_data_i     (mem_data_i),
    .mem_ready_o    (mem_ready_o),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .wr_row_o       (wr_row_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input int aa, input logic [63:0] ad,
                       input logic mv, input int ma, input logic [63:0] md);
    alu_valid_i = av;
    alu_addr_i  = 5'(aa);
    alu_data_i  = ad;
    mem_valid_i = mv;
    mem_addr_i  = 5'(ma);
    mem_data_i  = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ra, rm;
    int   ai, mi;
    reset  = 1'b1;
    hold_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // Requests during reset are never accepted.
    drive(1, 5, 64'h1, 1, 6, 64'h2);
    #1;
    check("rst_alu_rdy", alu_ready_o, 0);
    check("rst_mem_rdy", mem_ready_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check("idle_wr_en", wr_en_o, 0);
    check("idle_row", wr_row_o, 0);
    check("idle_cnt", conflict_cnt_o, 0);
    check("idle_addr", wr_addr_o, 0);
    check("idle_alu_rdy", alu_ready_o, 0);
    check("idle_mem_rdy", mem_ready_o, 0);

    // Single ALU write.
    drive(1, 5, 64'hDEAD, 0, 0, 0);
    #1;
    check("alu1_rdy", alu_ready_o, 1);
    check("alu1_mem_rdy", mem_ready_o, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("alu1_wr_en", wr_en_o, 1);
    check("alu1_addr", wr_addr_o, 5);
    check("alu1_data", wr_data_o, 64'hDEAD);
    check("alu1_row", wr_row_o, 32'h0000_0020);

    // Load to the zero register: accepted, write suppressed.
    drive(0, 0, 0, 1, 31, 64'h1234);
    #1;
    check("xzr_rdy", mem_ready_o, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("xzr_wr_en", wr_en_o, 0);
    check("xzr_row", wr_row_o, 0);
    check("xzr_addr", wr_addr_o, 31);
    step();
    check("hold_addr", wr_addr_o, 31);
    check("hold_data", wr_data_o, 64'h1234);
    check("noxfer_en", wr_en_o, 0);

    // Continuous conflict; last grant is MEM so ALU goes first.
    ai = 0;
    mi = 0;
    for (int k = 0; k < 5; k++) begin
      drive(ai < 3, (ai < 3) ? alu_q[ai] : 0, (ai < 3) ? 64'hA000 + 64'(alu_q[ai]) : 64'h0,
            mi < 2, (mi < 2) ? mem_q[mi] : 0, (mi < 2) ? 64'hB000 + 64'(mem_q[mi]) : 64'h0);
      #1;
      ra = alu_ready_o;
      rm = mem_ready_o;
      check($sformatf("cf%0d_alu_rdy", k), ra, 64'(exp_alu[k]));
      check($sformatf("cf%0d_mem_rdy", k), rm, 64'(1 - exp_alu[k]));
      step();
      check($sformatf("cf%0d_addr", k), wr_addr_o, 64'(exp_addr[k]));
      check($sformatf("cf%0d_data", k), wr_data_o, 64'(exp_data[k]));
      check($sformatf("cf%0d_en", k), wr_en_o, 1);
      if (ra) ai++;
      if (rm) mi++;
    end
    drive(0, 0, 0, 0, 0, 0);
    check("cf_cnt", conflict_cnt_o, 4);

    // Last grant is ALU: MEM wins, then hold freezes grants.
    drive(1, 8, 64'h88, 1, 9, 64'h99);
    #1;
    check("pre_hold_mem_rdy", mem_ready_o, 1);
    step();
    hold_i = 1'b1;
    drive(1, 8, 64'h88, 1, 10, 64'hAA);
    #1;
    check("hold_inflight_en", wr_en_o, 1);
    check("hold_inflight_addr", wr_addr_o, 9);
    check("hold_cnt0", conflict_cnt_o, 5);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_alu_rdy", k), alu_ready_o, 0);
      check($sformatf("hold%0d_mem_rdy", k), mem_ready_o, 0);
      step();
      check($sformatf("hold%0d_en", k), wr_en_o, 0);
      check($sformatf("hold%0d_cnt", k), conflict_cnt_o, 5);
    end
    hold_i = 1'b0;
    #1;
    check("rel_alu_rdy", alu_ready_o, 1);
    check("rel_mem_rdy", mem_ready_o, 0);
    step();
    drive(0, 8, 64'h88, 1, 10, 64'hAA);
    check("rel_addr", wr_addr_o, 8);
    check("rel_cnt", conflict_cnt_o, 6);
    #1;
    check("rel_mem_rdy2", mem_ready_o, 1);
    step();
    check("rel_addr2", wr_addr_o, 10);
    check("rel_row2", wr_row_o, 32'h0000_0400);
    check("rel_cnt2", conflict_cnt_o, 6);

    // Saturation of the conflict counter.
    drive(1, 12, 64'hC, 1, 13, 64'hD);
    repeat (300) step();
    check("sat_cnt", conflict_cnt_o, 255);
    check("sat_en", wr_en_o, 1);

    // Reset right after a grant discards the registered write.
    reset = 1'b1;
    #1;
    check("mrst_alu_rdy", alu_ready_o, 0);
    check("mrst_mem_rdy", mem_ready_o, 0);
    step();
    check("mrst_en", wr_en_o, 0);
    check("mrst_row", wr_row_o, 0);
    check("mrst_cnt", conflict_cnt_o, 0);
    check("mrst_addr", wr_addr_o, 0);
    reset = 1'b0;
    #1;
    check("post_rst_alu_rdy", alu_ready_o, 1);
    check("post_rst_mem_rdy", mem_ready_o, 0);
    step();
    check("post_rst_addr", wr_addr_o, 12);
    check("post_rst_cnt", conflict_cnt_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
